amm_cmd_master: RTL and testbench

AMM_CMD_MASTER -- requirements
Module: amm_cmd_master

---
 rtl/amm_master_pkg.sv | 31 +++
 rtl/amm_timeout_cnt.sv | 40 ++++
 rtl/amm_cmd_master.sv | 156 +++++++++++++++
 tb/tb_amm_cmd_master.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/amm_master_pkg.sv
// Shared types for the Avalon-MM command master.
// Holds the register-file geometry (32 x 16-bit), the master FSM state enum and
// the command / response record typedefs used by the master and its environment.
package amm_master_pkg;

  localparam int unsigned RegAddrW = 5;
  localparam int unsigned RegDataW = 16;
  localparam int unsigned RegBeW   = RegDataW / 8;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRdReq,
    StRdWait,
    StRsp
  } amm_state_e;

  typedef struct packed {
    logic                write;
    logic [RegAddrW-1:0] addr;
    logic [RegDataW-1:0] wrdata;
    logic [RegBeW-1:0]   byteen;
  } amm_cmd_t;

  typedef struct packed {
    logic                write;
    logic                timeout;
    logic [RegDataW-1:0] rddata;
  } amm_rsp_t;

endpackage

// File: rtl/amm_timeout_cnt.sv
// Saturating cycle counter with synchronous clear and count enable.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   clr_i          : force the count to zero on the next edge (wins over en_i)
//   en_i           : count up by one per cycle, holding at MaxVal
//   hit_o          : count currently equals MaxVal
module amm_timeout_cnt #(
  parameter int unsigned MaxVal = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam int unsigned CntW = (MaxVal < 2) ? 1 : $clog2(MaxVal + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign hit_o = (cnt_q == CntW'(MaxVal));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !hit_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/amm_cmd_master.sv
// Single-outstanding command-to-Avalon-MM master.
// Accepts one command (valid/ready), issues one Avalon-MM write or read with
// waitrequest and readdatavalid handling, then presents one response
// (valid/ready). Every bus phase is bounded by a TIMEOUT-cycle watchdog; on
// expiry the strobe drops and a response with rsp_timeout_o=1 and zero data is
// returned.
// Ports:
//   clk_i, rst_n_i       : clock, asynchronous active-low reset
//   cmd_*                : command stream (write flag, word address, data, byte enables)
//   rsp_*                : response stream (read data, command type, timeout flag)
//   amm_*                : Avalon-MM master port
module amm_cmd_master
  import amm_master_pkg::*;
#(
  parameter int unsigned ADDR_W  = RegAddrW,
  parameter int unsigned DATA_W  = RegDataW,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_write_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_wrdata_i,
  input  logic [DATA_W/8-1:0] cmd_byteen_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rddata_o,
  output logic                rsp_write_o,
  output logic                rsp_timeout_o,
  output logic [ADDR_W-1:0]   amm_address_o,
  output logic                amm_write_o,
  output logic                amm_read_o,
  output logic [DATA_W-1:0]   amm_writedata_o,
  output logic [DATA_W/8-1:0] amm_byteenable_o,
  input  logic                amm_waitrequest_i,
  input  logic [DATA_W-1:0]   amm_readdata_i,
  input  logic                amm_readdatavalid_i
);

  amm_state_e state_q, state_d;

  logic                cmd_write_q;
  logic [ADDR_W-1:0]   cmd_addr_q;
  logic [DATA_W-1:0]   cmd_wrdata_q;
  logic [DATA_W/8-1:0] cmd_byteen_q;

  logic                rsp_write_q, rsp_timeout_q;
  logic [DATA_W-1:0]   rsp_rddata_q;

  logic accept, to_hit, cnt_clr, cnt_en, rsp_load;

  assign accept   = cmd_valid_i && cmd_ready_o;
  // Counter restarts on every state change so each bus phase gets its own budget.
  assign cnt_clr  = (state_d != state_q);
  assign cnt_en   = (state_q == StWr) || (state_q == StRdReq) || (state_q == StRdWait);
  assign rsp_load = (state_q != StRsp) && (state_d == StRsp);

  amm_timeout_cnt #(
    .MaxVal(TIMEOUT)
  ) u_timeout_cnt (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .hit_o  (to_hit)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the watchdog takes priority over any bus handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = cmd_write_i ? StWr : StRdReq;
      end
      StWr: begin
        if (to_hit || !amm_waitrequest_i) state_d = StRsp;
      end
      StRdReq: begin
        if (to_hit) begin
          state_d = StRsp;
        end else if (!amm_waitrequest_i) begin
          // Zero-latency slaves return data in the same cycle the read is taken.
          state_d = amm_readdatavalid_i ? StRsp : StRdWait;
        end
      end
      StRdWait: begin
        if (to_hit || amm_readdatavalid_i) state_d = StRsp;
      end
      StRsp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    cmd_ready_o = 1'b0;
    amm_write_o = 1'b0;
    amm_read_o  = 1'b0;
    rsp_valid_o = 1'b0;
    unique case (state_q)
      // Gated by reset so ready reads 0 while reset is held.
      StIdle:   cmd_ready_o = rst_n_i;
      StWr:     amm_write_o = !to_hit;
      StRdReq:  amm_read_o  = !to_hit;
      StRsp:    rsp_valid_o = 1'b1;
      default:  ;
    endcase
  end

  // Command and response holding registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cmd_write_q   <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_wrdata_q  <= '0;
      cmd_byteen_q  <= '0;
      rsp_write_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rddata_q  <= '0;
    end else begin
      if (accept) begin
        cmd_write_q  <= cmd_write_i;
        cmd_addr_q   <= cmd_addr_i;
        cmd_wrdata_q <= cmd_wrdata_i;
        cmd_byteen_q <= cmd_byteen_i;
      end
      // Loaded only on entry to StRsp, so the response is frozen while it waits.
      if (rsp_load) begin
        rsp_write_q   <= cmd_write_q;
        rsp_timeout_q <= to_hit;
        rsp_rddata_q  <= (to_hit || cmd_write_q) ? '0 : amm_readdata_i;
      end
    end
  end

  assign amm_address_o    = cmd_addr_q;
  assign amm_writedata_o  = cmd_wrdata_q;
  assign amm_byteenable_o = cmd_byteen_q;
  assign rsp_write_o      = rsp_write_q;
  assign rsp_timeout_o    = rsp_timeout_q;
  assign rsp_rddata_o     = rsp_rddata_q;

endmodule

// File: tb/tb_amm_cmd_master.sv
// Randomised bench for amm_cmd_master with an Avalon-MM register-file slave
// and a transaction-level reference model.
module tb_amm_cmd_master;
  import amm_master_pkg::*;

  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [4:0]  cmd_addr = '0;
  logic [15:0] cmd_wrdata = '0;
  logic [1:0]  cmd_byteen = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write, rsp_timeout;
  logic [15:0] rsp_rddata;
  logic [4:0]  amm_address;
  logic        amm_write, amm_read, amm_waitrequest, amm_readdatavalid;
  logic [15:0] amm_writedata, amm_readdata;
  logic [1:0]  amm_byteenable;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  amm_cmd_master #(
    .ADDR_W (5),
    .DATA_W (16),
    .TIMEOUT(TO)
  ) dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .cmd_valid_i        (cmd_valid),
    .cmd_ready_o        (cmd_ready),
    .cmd_write_i        (cmd_write),
    .cmd_addr_i         (cmd_addr),
    .cmd_wrdata_i       (cmd_wrdata),
    .cmd_byteen_i       (cmd_byteen),
    .rsp_valid_o        (rsp_valid),
    .rsp_ready_i        (rsp_ready),
    .rsp_rddata_o       (rsp_rddata),
    .rsp_write_o        (rsp_write),
    .rsp_timeout_o      (rsp_timeout),
    .amm_address_o      (amm_address),
    .amm_write_o        (amm_write),
    .amm_read_o         (amm_read),
    .amm_writedata_o    (amm_writedata),
    .amm_byteenable_o   (amm_byteenable),
    .amm_waitrequest_i  (amm_waitrequest),
    .amm_readdata_i     (amm_readdata),
    .amm_readdatavalid_i(amm_readdatavalid)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] reset_val(input int i);
    case (i % 4)
      0: return 16'hAAAA;
      1: return 16'hBBBB;
      2: return 16'hCCCC;
      default: return 16'hDDDD;
    endcase
  endfunction

  function automatic logic [15:0] ro_mask(input int i);
    case (i % 4)
      0: return 16'h0000;
      1: return 16'h00FF;
      2: return 16'hFF00;
      default: return 16'hFFFF;
    endcase
  endfunction

  // ---------------- slave model ----------------
  int          knob_wait = 0;   // waitrequest-high cycles per strobe
  int          knob_lat  = 1;   // readdatavalid delay after the read is taken; <0 = never
  logic        junk_rdv  = 1'b0;
  logic [15:0] slv_regs [32];
  int          sl_wcnt;
  int          pend;
  logic [15:0] pend_data;

  always_comb amm_waitrequest = (amm_read || amm_write) && (sl_wcnt < knob_wait);
  always_comb amm_readdatavalid = (knob_lat == 0 && amm_read && !amm_waitrequest) ||
                                  (pend == 0) || junk_rdv;
  always_comb amm_readdata = (pend == 0) ? pend_data :
                             (junk_rdv ? 16'hDEAD : slv_regs[amm_address]);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) slv_regs[i] <= reset_val(i);
      sl_wcnt   <= 0;
      pend      <= -1;
      pend_data <= '0;
    end else begin
      if (pend >= 0) pend <= pend - 1;
      if ((amm_read || amm_write) && amm_waitrequest) begin
        sl_wcnt <= sl_wcnt + 1;
      end else begin
        sl_wcnt <= 0;
        if (amm_write) begin
          slv_regs[amm_address] <= (slv_regs[amm_address] &
              ~({{8{amm_byteenable[1]}}, {8{amm_byteenable[0]}}} & ~ro_mask(int'(amm_address)))) |
              (amm_writedata &
              ({{8{amm_byteenable[1]}}, {8{amm_byteenable[0]}}} & ~ro_mask(int'(amm_address))));
        end
        if (amm_read && knob_lat > 0) begin
          pend      <= knob_lat - 1;
          pend_data <= slv_regs[amm_address];
        end
      end
    end
  end

  // ---------------- bus monitor: length and stability of each strobe burst ----------------
  int          mon_strb  = 0;
  logic        mon_err   = 1'b0;
  logic        prev_strb = 1'b0;
  logic [24:0] mon_snap  = '0;

  always @(negedge clk) begin
    if (amm_read || amm_write) begin
      if (!prev_strb) begin
        mon_strb <= 1;
        mon_err  <= amm_read && amm_write;
        mon_snap <= {amm_write, amm_address, amm_writedata, amm_byteenable};
      end else begin
        mon_strb <= mon_strb + 1;
        if ((amm_read && amm_write) ||
            mon_snap != {amm_write, amm_address, amm_writedata, amm_byteenable})
          mon_err <= 1'b1;
      end
    end
    prev_strb <= amm_read || amm_write;
  end

  // ---------------- reference model ----------------
  logic [15:0] ref_regs [32];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ref_regs[i] = reset_val(i);
  endtask

  task automatic ref_write(input int a, input logic [15:0] d, input logic [1:0] be);
    logic [15:0] ro;
    ro = ro_mask(a);
    for (int b = 0; b < 2; b++)
      if (be[b])
        for (int i = 8 * b; i < 8 * b + 8; i++)
          if (!ro[i]) ref_regs[a][i] = d[i];
  endtask

  // One full transaction: send command, wait for response, hold it, consume it.
  task automatic run_txn(input amm_cmd_t c, input int wt, input int lat, input int hold,
                         input bit junk, output logic [15:0] got_data);
    amm_rsp_t    exp;
    int          exp_lat, cycles, g;
    logic        hold_bad;
    logic [17:0] first;
    if (!c.write && lat < 0) begin
      exp     = '{write: 1'b0, timeout: 1'b1, rddata: 16'h0000};
      exp_lat = wt + TO + 2;
    end else if (c.write) begin
      ref_write(int'(c.addr), c.wrdata, c.byteen);
      exp     = '{write: 1'b1, timeout: 1'b0, rddata: 16'h0000};
      exp_lat = wt + 1;
    end else begin
      exp     = '{write: 1'b0, timeout: 1'b0, rddata: ref_regs[c.addr]};
      exp_lat = wt + 1 + lat;
    end
    knob_wait = wt;
    knob_lat  = lat;
    @(negedge clk);
    g = 0;
    while (!cmd_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    check_eq("cmd_ready_idle", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_write  = c.write;
    cmd_addr   = c.addr;
    cmd_wrdata = c.wrdata;
    cmd_byteen = c.byteen;
    @(negedge clk);
    cmd_valid = 1'b0;
    junk_rdv  = junk && c.write;
    cycles = 0;
    while (!rsp_valid && cycles < TO + 20) begin
      @(negedge clk);
      cycles++;
    end
    check_eq("rsp_valid", rsp_valid, 1);
    check_eq("latency", cycles, exp_lat);
    first    = {rsp_write, rsp_timeout, rsp_rddata};
    hold_bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if ({rsp_write, rsp_timeout, rsp_rddata} != first || cmd_ready || !rsp_valid)
        hold_bad = 1'b1;
    end
    if (hold > 0) check_eq("rsp_hold", hold_bad, 0);
    check_eq("rsp_write", rsp_write, exp.write);
    check_eq("rsp_timeout", rsp_timeout, exp.timeout);
    check_eq("rsp_rddata", rsp_rddata, exp.rddata);
    got_data  = rsp_rddata;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    junk_rdv  = 1'b0;
    check_eq("rsp_single", rsp_valid, 0);
    check_eq("strobe_cycles", mon_strb, wt + 1);
    check_eq("bus_stable", mon_err, 0);
  endtask

  initial begin
    amm_cmd_t    c;
    logic [15:0] d;
    int          n_acc, n_rsp;
    logic        stale;

    model_reset();
    #3;
    check_eq("rst_cmd_ready", cmd_ready, 0);
    check_eq("rst_strobes", {amm_read, amm_write}, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_data", {rsp_write, rsp_timeout, rsp_rddata}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after_rst", cmd_ready, 1);

    // Read addr 3, zero wait, data one cycle later.
    c = '{write: 1'b0, addr: 5'd3, wrdata: 16'h0, byteen: 2'b11};
    run_txn(c, 0, 1, 0, 1'b0, d);
    check_eq("rd3_dddd", d, 16'hDDDD);

    // Write FFFF to addr 1 (lower byte read-only), then read back.
    c = '{write: 1'b1, addr: 5'd1, wrdata: 16'hFFFF, byteen: 2'b11};
    run_txn(c, 0, 1, 0, 1'b0, d);
    c = '{write: 1'b0, addr: 5'd1, wrdata: 16'h0, byteen: 2'b11};
    run_txn(c, 0, 1, 0, 1'b0, d);
    check_eq("rd1_ffbb", d, 16'hFFBB);

    // Write with 4 wait cycles; strobe length checked inside run_txn.
    c = '{write: 1'b1, addr: 5'd6, wrdata: 16'h1234, byteen: 2'b11};
    run_txn(c, 4, 1, 0, 1'b0, d);

    // Read with readdatavalid never arriving, then a normal read.
    c = '{write: 1'b0, addr: 5'd2, wrdata: 16'h0, byteen: 2'b11};
    run_txn(c, 0, -1, 0, 1'b0, d);
    c = '{write: 1'b0, addr: 5'd0, wrdata: 16'h0, byteen: 2'b11};
    run_txn(c, 0, 1, 0, 1'b0, d);
    check_eq("rd0_after_to", d, 16'hAAAA);

    // Response back-pressure for 10 cycles.
    c = '{write: 1'b0, addr: 5'd6, wrdata: 16'h0, byteen: 2'b11};
    run_txn(c, 1, 2, 10, 1'b0, d);

    // Back-to-back reads with the response always accepted.
    knob_wait = 0;
    knob_lat  = 1;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 5'd3;
    rsp_ready = 1'b1;
    n_acc = 0;
    n_rsp = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) n_acc++;
      if (rsp_valid) begin
        n_rsp++;
        check_eq("b2b_data", rsp_rddata, ref_regs[3]);
      end
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("b2b_accepts", n_acc, 5);
    check_eq("b2b_responses", n_rsp, 5);
    repeat (6) @(negedge clk);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      c.write  = 1'($urandom_range(0, 1));
      c.addr   = 5'($urandom_range(0, 31));
      c.wrdata = 16'($urandom);
      c.byteen = 2'($urandom_range(0, 3));
      run_txn(c, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), d);
    end

    // Reset during RD_WAIT (wt=0) and during a stalled RD_REQ (wt=50).
    for (int v = 0; v < 2; v++) begin
      knob_wait = (v == 0) ? 0 : 50;
      knob_lat  = -1;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 5'd2;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      check_eq("pre_rst_read", amm_read, (v == 1));
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("rst_mid_strobes", {amm_read, amm_write}, 0);
      check_eq("rst_mid_rsp_valid", rsp_valid, 0);
      check_eq("rst_mid_cmd_ready", cmd_ready, 0);
      model_reset();
      knob_wait = 0;
      knob_lat  = 1;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("post_rst_ready", cmd_ready, 1);
      stale = 1'b0;
      repeat (5) begin
        @(negedge clk);
        if (rsp_valid) stale = 1'b1;
      end
      check_eq("no_stale_rsp", stale, 0);
    end

    // Normal operation after reset, including register-file reset values.
    c = '{write: 1'b0, addr: 5'd1, wrdata: 16'h0, byteen: 2'b11};
    run_txn(c, 0, 1, 0, 1'b0, d);
    check_eq("rd1_after_rst", d, 16'hBBBB);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
